// File: rtl/lsu_align_splitter_if.sv
// Request/response and datamemory bus of the LSU align splitter.
// The master drives requests and memory read data; the slave is the splitter.
interface lsu_align_splitter_if #(
   parameter int DM_ADDRESS = 9,
   parameter int DATA_W     = 32
);
   logic                  req_valid;
   logic                  req_ready;
   logic                  req_we;
   logic [2:0]            req_funct3;
   logic [DM_ADDRESS-1:0] req_addr;
   logic [DATA_W-1:0]     req_wdata;
   logic                  resp_valid;
   logic [DATA_W-1:0]     resp_rdata;
   logic                  dm_MemRead;
   logic                  dm_MemWrite;
   logic [DM_ADDRESS-1:0] dm_a;
   logic [DATA_W-1:0]     dm_wd;
   logic [2:0]            dm_Funct3;
   logic [DATA_W-1:0]     dm_rd;
   logic [7:0]            misalign_cnt;

   modport master (
      output req_valid, req_we, req_funct3, req_addr, req_wdata, dm_rd,
      input  req_ready, resp_valid, resp_rdata, dm_MemRead, dm_MemWrite,
             dm_a, dm_wd, dm_Funct3, misalign_cnt
   );

   modport slave (
      input  req_valid, req_we, req_funct3, req_addr, req_wdata, dm_rd,
      output req_ready, resp_valid, resp_rdata, dm_MemRead, dm_MemWrite,
             dm_a, dm_wd, dm_Funct3, misalign_cnt
   );
endinterface

// File: rtl/lsu_align_splitter.sv
// Splits misaligned RISC-V loads/stores into word reads and byte writes for a
// word-organised datamemory, and counts the misaligned requests it accepts.
module lsu_align_splitter #(
   parameter int DM_ADDRESS = 9,
   parameter int DATA_W     = 32
) (
   input logic                 clk,
   input logic                 reset,
   lsu_align_splitter_if.slave bus
);
   typedef enum logic [2:0] {IDLE, LD0, LD1, ST, RESP} state_t;

   state_t                state_q, state_d;
   logic [2:0]            funct3_q, funct3_d;
   logic [DM_ADDRESS-1:0] addr_q, addr_d;
   logic [DATA_W-1:0]     wdata_q, wdata_d;
   logic                  misal_q, misal_d;
   logic [DATA_W-1:0]     word0_q, word0_d;
   logic [DATA_W-1:0]     rdata_q, rdata_d;
   logic [1:0]            byteCnt_q, byteCnt_d;
   logic [7:0]            misalignCnt_q, misalignCnt_d;

   logic [2:0]            reqSize;
   logic [2:0]            curSize;
   logic                  reqMisaligned;
   logic [1:0]            offset;
   logic                  crossing;
   logic [DM_ADDRESS-1:0] wordAddr;
   logic [2*DATA_W-1:0]   loadPair;
   logic [DATA_W-1:0]     loadShifted;
   logic [DATA_W-1:0]     loadResult;
   logic [7:0]            storeByte;

   function automatic logic [2:0] sizeOf(input logic [1:0] f);
      case (f)
         2'b00:   sizeOf = 3'd1;
         2'b01:   sizeOf = 3'd2;
         default: sizeOf = 3'd4;
      endcase
   endfunction

   always_comb begin
      reqSize       = sizeOf(bus.req_funct3[1:0]);
      reqMisaligned = ((reqSize == 3'd2) && bus.req_addr[0]) ||
                      ((reqSize == 3'd4) && (bus.req_addr[1:0] != 2'b00));
      curSize       = sizeOf(funct3_q[1:0]);
      offset        = addr_q[1:0];
      crossing      = ({2'b00, offset} + {1'b0, curSize}) > 4'd4;
      wordAddr      = {addr_q[DM_ADDRESS-1:2], 2'b00};
      storeByte     = 8'(wdata_q >> {byteCnt_q, 3'b000});
   end

   // Load result: pick bytes offset..offset+size-1 of {second word, first word}.
   always_comb begin
      loadPair    = (state_q == LD1) ? {bus.dm_rd, word0_q} : {{DATA_W{1'b0}}, bus.dm_rd};
      loadShifted = DATA_W'(loadPair >> {offset, 3'b000});
      case (funct3_q[1:0])
         2'b00:   loadResult = funct3_q[2] ? {{(DATA_W-8){1'b0}}, loadShifted[7:0]}
                                           : {{(DATA_W-8){loadShifted[7]}}, loadShifted[7:0]};
         2'b01:   loadResult = funct3_q[2] ? {{(DATA_W-16){1'b0}}, loadShifted[15:0]}
                                           : {{(DATA_W-16){loadShifted[15]}}, loadShifted[15:0]};
         default: loadResult = loadShifted;
      endcase
   end

   always_comb begin
      state_d         = state_q;
      funct3_d        = funct3_q;
      addr_d          = addr_q;
      wdata_d         = wdata_q;
      misal_d         = misal_q;
      word0_d         = word0_q;
      rdata_d         = rdata_q;
      byteCnt_d       = byteCnt_q;
      misalignCnt_d   = misalignCnt_q;
      bus.req_ready   = 1'b0;
      bus.resp_valid  = 1'b0;
      bus.dm_MemRead  = 1'b0;
      bus.dm_MemWrite = 1'b0;
      bus.dm_a        = '0;
      bus.dm_wd       = '0;
      bus.dm_Funct3   = 3'b000;

      case (state_q)
         IDLE: begin
            bus.req_ready = 1'b1;
            if (bus.req_valid) begin
               funct3_d  = bus.req_funct3;
               addr_d    = bus.req_addr;
               wdata_d   = bus.req_wdata;
               misal_d   = reqMisaligned;
               byteCnt_d = 2'd0;
               if (reqMisaligned && (misalignCnt_q != 8'hFF)) begin
                  misalignCnt_d = misalignCnt_q + 8'd1;
               end
               state_d = bus.req_we ? ST : LD0;
            end
         end
         LD0: begin
            bus.dm_MemRead = 1'b1;
            bus.dm_a       = wordAddr;
            bus.dm_Funct3  = 3'b010;
            word0_d        = bus.dm_rd;
            if (crossing) begin
               state_d = LD1;
            end else begin
               rdata_d = loadResult;
               state_d = RESP;
            end
         end
         LD1: begin
            bus.dm_MemRead = 1'b1;
            bus.dm_a       = wordAddr + DM_ADDRESS'(4);
            bus.dm_Funct3  = 3'b010;
            rdata_d        = loadResult;
            state_d        = RESP;
         end
         ST: begin
            bus.dm_MemWrite = 1'b1;
            if (!misal_q) begin
               bus.dm_a      = addr_q;
               bus.dm_Funct3 = funct3_q;
               bus.dm_wd     = wdata_q;
               rdata_d       = '0;
               state_d       = RESP;
            end else begin
               // Misaligned stores go out one byte per cycle, lowest byte first.
               bus.dm_a      = addr_q + DM_ADDRESS'(byteCnt_q);
               bus.dm_Funct3 = 3'b000;
               bus.dm_wd     = {{(DATA_W-8){1'b0}}, storeByte};
               if ({1'b0, byteCnt_q} == (curSize - 3'd1)) begin
                  byteCnt_d = 2'd0;
                  rdata_d   = '0;
                  state_d   = RESP;
               end else begin
                  byteCnt_d = byteCnt_q + 2'd1;
               end
            end
         end
         RESP: begin
            bus.resp_valid = 1'b1;
            state_d        = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= IDLE;
         funct3_q      <= 3'b000;
         addr_q        <= '0;
         wdata_q       <= '0;
         misal_q       <= 1'b0;
         word0_q       <= '0;
         rdata_q       <= '0;
         byteCnt_q     <= 2'd0;
         misalignCnt_q <= 8'd0;
      end else begin
         state_q       <= state_d;
         funct3_q      <= funct3_d;
         addr_q        <= addr_d;
         wdata_q       <= wdata_d;
         misal_q       <= misal_d;
         word0_q       <= word0_d;
         rdata_q       <= rdata_d;
         byteCnt_q     <= byteCnt_d;
         misalignCnt_q <= misalignCnt_d;
      end
   end

   assign bus.resp_rdata   = rdata_q;
   assign bus.misalign_cnt = misalignCnt_q;
endmodule

// File: doc/lsu_align_splitter.md
LSU_ALIGN_SPLITTER -- requirements
Module: lsu_align_splitter

Interface
REQ-001 SHALL have parameter DM_ADDRESS, default 9, byte-address width toward datamemory.
REQ-002 SHALL have parameter DATA_W, default 32, data width.
REQ-003 SHALL have port clk  input  1  the only clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port req_valid  input  1  pipeline memory request present.
REQ-006 SHALL have port req_ready  output  1  block can accept a request; high only in IDLE.
REQ-007 SHALL have port req_we  input  1  1 = store, 0 = load.
REQ-008 SHALL have port req_funct3  input  3  RISC-V funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW).
REQ-009 SHALL have port req_addr  input  DM_ADDRESS  byte address.
REQ-010 SHALL have port req_wdata  input  DATA_W  store data.
REQ-011 SHALL have port resp_valid  output  1  one-cycle completion pulse.
REQ-012 SHALL have port resp_rdata  output  DATA_W  extended load result; 0 for stores.
REQ-013 SHALL have ports dm_MemRead and dm_MemWrite  output  1 each  datamemory strobes.
REQ-014 SHALL have ports dm_a  output  DM_ADDRESS, dm_wd  output  DATA_W, dm_Funct3  output  3  datamemory address, write data and funct3.
REQ-015 SHALL have port dm_rd  input  DATA_W  datamemory read data, valid in the same cycle dm_MemRead is high.
REQ-016 SHALL have port misalign_cnt  output  8  saturating count of accepted misaligned requests.

Function
REQ-017 SHALL use FSM states IDLE, LD0, LD1, ST, RESP; reset state IDLE.
REQ-018 SHALL capture we/funct3/addr/wdata on req_valid && req_ready; a request is accepted only in IDLE.
REQ-019 SHALL derive size from funct3[1:0]: 00 = 1 byte, 01 = 2 bytes, otherwise 4 bytes; o = addr[1:0].
REQ-020 SHALL classify a request as misaligned when size is 2 and addr[0] = 1, or size is 4 and o != 0.
REQ-021 SHALL issue loads only as dm_Funct3 = 010 at word address W = {addr[8:2], 2'b00}, in state LD0.
REQ-022 SHALL issue a second read at W+4 (mod 2^DM_ADDRESS) in LD1 when o + size > 4; otherwise SHALL go LD0 -> RESP.
REQ-023 SHALL form the load result from bytes o..o+size-1 of {LD1 word, LD0 word}, sign-extended for funct3 000/001 and zero-extended for 100/101.
REQ-024 SHALL issue an aligned store in one ST cycle, with dm_a = addr, dm_Funct3 = req_funct3, dm_wd = wdata.
REQ-025 SHALL issue a misaligned store as size consecutive ST cycles, each an SB (funct3 000) at addr+i (mod 2^DM_ADDRESS), with dm_wd[7:0] = wdata[8i+7:8i], for i = 0..size-1.
REQ-026 SHALL keep an internal byte counter for REQ-025 and go ST -> RESP after the last byte.
REQ-027 SHALL assert resp_valid for exactly the one RESP cycle, then return to IDLE.
REQ-028 SHALL hold resp_rdata stable from RESP until the next RESP.
REQ-029 SHALL have the following latency, for acceptance at cycle T:
- aligned or non-crossing load, or aligned store: resp_valid at T+2;
- crossing load: resp_valid at T+3;
- misaligned half store: resp_valid at T+3;
- misaligned word store: resp_valid at T+5.
REQ-030 SHALL hold dm_MemRead = dm_MemWrite = 0 outside LD0/LD1/ST, and SHALL never assert both at once.
REQ-031 SHALL increment misalign_cnt on each accepted misaligned request and saturate it at 255.

Reset
REQ-032 SHALL, on reset, set the following, overriding any in-flight request:
- FSM to IDLE;
- resp_valid, resp_rdata, dm strobes, dm_a, dm_wd, dm_Funct3, byte counter and misalign_cnt to 0;
- req_ready to 1 in the following cycle.
REQ-033 SHALL, on reset mid-operation, issue no further dm strobes from the next cycle and produce no resp_valid for the aborted request; bytes already written remain written.

Verification
REQ-034 SHALL be verified by: LW, addr 0x010, dm_rd = 0x8899AABB -> one read at dm_a = 0x010, resp_valid at T+2, resp_rdata = 0x8899AABB.
REQ-035 SHALL be verified by: LH, addr 0x013, LD0 dm_rd = 0x80FFEEDD, LD1 dm_rd = 0x11223381 -> reads at 0x010 then 0x014, resp_rdata = 0xFFFF8180, resp_valid at T+3, misalign_cnt = 1.
REQ-036 SHALL be verified by: SW, addr 0x1FE, wdata 0xA1B2C3D4 -> four SB cycles at 0x1FE, 0x1FF, 0x000, 0x001 with dm_wd[7:0] = D4, C3, B2, A1, resp_valid at T+5.
REQ-037 SHALL be verified by: SH, addr 0x022, wdata 0x0000BEEF -> one cycle, dm_Funct3 = 001, dm_a = 0x022, dm_wd = 0x0000BEEF, resp_rdata = 0.
REQ-038 SHALL be verified by: reset asserted during the 2nd SB of a misaligned SW -> no dm strobes next cycle, no resp_valid, req_ready = 1, misalign_cnt = 0.
REQ-039 SHALL be verified by: 256 misaligned LBU? no -- 256 misaligned LW requests -> misalign_cnt stops at 255; req_valid held high in RESP is not accepted until IDLE.
